rob_core: RTL
=============

ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 rob_core SHALL have the following ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- issue_sgn  in  1  allocate an entry this cycle.
- issue_rd  in  6  destination register; `NULL (6'd32) means none.
- issue_is_br  in  1  entry is a branch or jump.
- issue_pred  in  1  predicted taken.
- issue_pc  in  32  instruction PC.
- rob_new_entry  out  5  tag for the next allocation (combinational tail).
- rob_full  out  1  no allocation possible.
- wb_sgn  in  1  CDB writeback valid.
- wb_entry  in  5  CDB tag.
- wb_result  in  32  CDB value.
- wb_taken  in  1  actual branch outcome.
- wb_target  in  32  actual taken target.
- qj_entry, qk_entry  in  5  operand tag queries.
- qj_ready, qk_ready  out  1  queried entry has a result.
- qj_value, qk_value  out  32  queried result.
- commit_sgn  out  1  commit strobe (registered).
- rob_entry  out  5  committed tag.
- rob_des  out  6  committed destination.
- rob_result  out  32  committed value.
- rollback  out  1  flush strobe (registered).
- rollback_pc  out  32  redirect PC.

Function
REQ-002 The block SHALL be a 16-entry circular buffer with valid tags 0..15; `ENTRY_NULL` (5'd16) SHALL mean "no tag".
REQ-003 The block SHALL hold head and tail pointers (4 bits, wrapping 15->0) and a 5-bit count (0..16).
REQ-004 rob_full SHALL equal (count==16) OR rollback_pending; it SHALL be derived from registered state only, so a commit in the same cycle does not clear it.
REQ-005 On issue_sgn AND NOT rob_full, the block SHALL write rd, is_br, pred and pc into the tail entry, clear its ready bit, advance tail and increment count. An issue while full SHALL be ignored.
REQ-006 On wb_sgn with wb_entry != `ENTRY_NULL` naming a valid entry, the block SHALL store result, taken and target and set ready. A writeback to an invalid or NULL tag SHALL be ignored.
REQ-007 Each clock edge, if the head entry is valid and ready and no rollback is pending, the block SHALL register commit_sgn=1 with rob_entry=head, rob_des=rd and rob_result=result, free the entry and advance head. Otherwise commit_sgn SHALL be 0.
REQ-008 The block SHALL commit at most one entry per cycle. Writeback to the head in cycle N SHALL give commit_sgn high in cycle N+1.
REQ-009 Simultaneous issue and commit SHALL leave count unchanged.
REQ-010 A committed branch with taken != pred SHALL set rollback_pending. On the next edge the block SHALL assert rollback for exactly one cycle, set rollback_pc to target if taken else pc+4, and clear all entries, head, tail and count to 0.
REQ-011 While rollback_pending, issue and commit SHALL be blocked. Writebacks in the rollback cycle SHALL be discarded.
REQ-012 qj_ready/qj_value (and the qk pair) SHALL be combinational from the addressed entry. A NULL or invalid tag SHALL give ready=0 and value=0.
REQ-013 With rdy low, the block SHALL hold all state and drive commit_sgn=0 and rollback=0.

Reset
REQ-014 On rst the block SHALL clear all valid and ready bits and set head=tail=count=0 and rollback_pending=0.
REQ-015 On rst the block SHALL set commit_sgn=0, rollback=0, rob_entry=`ENTRY_NULL`, rob_des=`NULL`, rob_result=0 and rollback_pc=0.
REQ-016 Reset SHALL take priority over rdy, rollback and all other inputs, including mid-rollback.

Configuration
REQ-017 With ROB_BYPASS_EN defined, a query whose tag equals a same-cycle valid wb_entry SHALL return ready=1 and value=wb_result. Without the macro, queries SHALL reflect stored state only, so ready rises one cycle later.

Structure
REQ-018 ROBENTRY ([4:0]), `ENTRY_NULL`, `NULL`, ROB_SIZE (16), TRUE and FALSE SHALL live in the shared defines header.
REQ-019 The block SHALL be a single module; no sub-module is required.

Verification
REQ-020 Issue 16 entries with no writeback -> rob_full=1 and rob_new_entry=0; a 17th issue is ignored and count stays 16.
REQ-021 Issue tag 0 with rd=5, then writeback wb_entry=0, wb_result=32'h1234 in cycle N -> in cycle N+1 commit_sgn=1, rob_entry=0, rob_des=5, rob_result=32'h1234.
REQ-022 Write back tag 1 before tag 0 -> no commit until tag 0 is ready; then tags 0 and 1 commit in consecutive cycles.
REQ-023 Branch at pc=32'h100 with pred=0, written back taken=1, target=32'h200 -> branch commits; next cycle rollback=1, rollback_pc=32'h200, count=0, rob_new_entry=0.
REQ-024 Full ROB with head ready plus issue_sgn in the same cycle -> head commits and the issue is ignored; next cycle rob_full=0.
REQ-025 Query tag 3 in the same cycle as its writeback of 32'hABCD -> qj_ready=1 with qj_value=32'hABCD if ROB_BYPASS_EN is defined, else qj_ready=0 and ready rises the next cycle.

Source files
------------

// File: rtl/rob_core_pkg.sv
// rtl/rob_core_pkg.sv - shared ROB types, tag constants and helpers
package rob_core_pkg;

  localparam int ROB_SIZE = 16;

  typedef logic [4:0] robentry_t;
  typedef logic [3:0] robidx_t;

  localparam robentry_t  ENTRY_NULL = 5'd16;
  localparam logic [5:0] NULL       = 6'd32;
  localparam logic       TRUE       = 1'b1;
  localparam logic       FALSE      = 1'b0;

  // ST_FLUSH is the one-cycle "rollback pending" window after a mispredict commits
  typedef enum logic {ST_RUN, ST_FLUSH} rob_state_t;

  function automatic logic [31:0] redirect_pc(logic taken, logic [31:0] target, logic [31:0] pc);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/rob_core_if.sv
// rtl/rob_core_if.sv - issue/writeback/query/commit bundle of the reorder buffer
interface rob_core_if;
  logic        rdy;
  logic        issue_sgn;
  logic [5:0]  issue_rd;
  logic        issue_is_br;
  logic        issue_pred;
  logic [31:0] issue_pc;
  logic [4:0]  rob_new_entry;
  logic        rob_full;
  logic        wb_sgn;
  logic [4:0]  wb_entry;
  logic [31:0] wb_result;
  logic        wb_taken;
  logic [31:0] wb_target;
  logic [4:0]  qj_entry;
  logic [4:0]  qk_entry;
  logic        qj_ready;
  logic        qk_ready;
  logic [31:0] qj_value;
  logic [31:0] qk_value;
  logic        commit_sgn;
  logic [4:0]  rob_entry;
  logic [5:0]  rob_des;
  logic [31:0] rob_result;
  logic        rollback;
  logic [31:0] rollback_pc;

  modport master (
    output rdy, issue_sgn, issue_rd, issue_is_br, issue_pred, issue_pc,
           wb_sgn, wb_entry, wb_result, wb_taken, wb_target, qj_entry, qk_entry,
    input  rob_new_entry, rob_full, qj_ready, qk_ready, qj_value, qk_value,
           commit_sgn, rob_entry, rob_des, rob_result, rollback, rollback_pc
  );

  modport slave (
    input  rdy, issue_sgn, issue_rd, issue_is_br, issue_pred, issue_pc,
           wb_sgn, wb_entry, wb_result, wb_taken, wb_target, qj_entry, qk_entry,
    output rob_new_entry, rob_full, qj_ready, qk_ready, qj_value, qk_value,
           commit_sgn, rob_entry, rob_des, rob_result, rollback, rollback_pc
  );
endinterface

// File: rtl/rob_core.sv
// rtl/rob_core.sv - 16-entry reorder buffer with in-order commit and mispredict rollback
// Optional same-cycle writeback bypass on operand queries: define ROB_BYPASS_EN.
module rob_core
  import rob_core_pkg::*;
(
  input logic       clk,
  input logic       rst,
  rob_core_if.slave rob
);

  logic [ROB_SIZE-1:0] valid_q, ready_q;
  logic [5:0]          rd_q     [ROB_SIZE];
  logic                br_q     [ROB_SIZE];
  logic                pred_q   [ROB_SIZE];
  logic                taken_q  [ROB_SIZE];
  logic [31:0]         pc_q     [ROB_SIZE];
  logic [31:0]         result_q [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];

  robidx_t     head_q, tail_q;
  logic [4:0]  count_q, count_d;
  rob_state_t  state_q;
  logic [31:0] flush_pc_q;

  logic        commit_q, rollback_q;
  robentry_t   entry_q;
  logic [5:0]  des_q;
  logic [31:0] res_q, rollback_pc_q;

  logic    full, do_commit, do_issue, do_wb, mispredict;
  robidx_t wb_idx;

  // full looks only at registered state, so a same-cycle commit cannot admit an issue
  assign full       = (count_q == 5'd16) || (state_q == ST_FLUSH);
  assign do_commit  = (state_q == ST_RUN) && valid_q[head_q] && ready_q[head_q];
  assign do_issue   = rob.issue_sgn && !full;
  assign wb_idx     = rob.wb_entry[3:0];
  assign do_wb      = rob.wb_sgn && !rob.wb_entry[4] && valid_q[wb_idx] && (state_q == ST_RUN);
  assign mispredict = br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
  assign count_d    = count_q + {4'd0, do_issue} - {4'd0, do_commit};

  function automatic logic stored_ready(robentry_t tag);
    return !tag[4] && valid_q[tag[3:0]] && ready_q[tag[3:0]];
  endfunction

  function automatic logic [31:0] stored_value(robentry_t tag);
    return stored_ready(tag) ? result_q[tag[3:0]] : 32'd0;
  endfunction

`ifdef ROB_BYPASS_EN
  logic wb_live, qj_hit, qk_hit;
  assign wb_live      = rob.rdy && do_wb;
  assign qj_hit       = wb_live && (rob.qj_entry == rob.wb_entry);
  assign qk_hit       = wb_live && (rob.qk_entry == rob.wb_entry);
  assign rob.qj_ready = qj_hit || stored_ready(rob.qj_entry);
  assign rob.qk_ready = qk_hit || stored_ready(rob.qk_entry);
  assign rob.qj_value = qj_hit ? rob.wb_result : stored_value(rob.qj_entry);
  assign rob.qk_value = qk_hit ? rob.wb_result : stored_value(rob.qk_entry);
`else
  assign rob.qj_ready = stored_ready(rob.qj_entry);
  assign rob.qk_ready = stored_ready(rob.qk_entry);
  assign rob.qj_value = stored_value(rob.qj_entry);
  assign rob.qk_value = stored_value(rob.qk_entry);
`endif

  assign rob.rob_new_entry = {1'b0, tail_q};
  assign rob.rob_full      = full;
  assign rob.commit_sgn    = commit_q;
  assign rob.rob_entry     = entry_q;
  assign rob.rob_des       = des_q;
  assign rob.rob_result    = res_q;
  assign rob.rollback      = rollback_q;
  assign rob.rollback_pc   = rollback_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= ST_RUN;
      flush_pc_q    <= '0;
      commit_q      <= FALSE;
      rollback_q    <= FALSE;
      entry_q       <= ENTRY_NULL;
      des_q         <= NULL;
      res_q         <= '0;
      rollback_pc_q <= '0;
    end else if (!rob.rdy) begin
      commit_q   <= FALSE;
      rollback_q <= FALSE;
    end else if (state_q == ST_FLUSH) begin
      commit_q      <= FALSE;
      rollback_q    <= TRUE;
      rollback_pc_q <= flush_pc_q;
      valid_q       <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= ST_RUN;
    end else begin
      commit_q   <= do_commit;
      rollback_q <= FALSE;
      if (do_wb) begin
        ready_q[wb_idx]  <= TRUE;
        result_q[wb_idx] <= rob.wb_result;
        taken_q[wb_idx]  <= rob.wb_taken;
        target_q[wb_idx] <= rob.wb_target;
      end
      // head and tail never coincide here: commit needs count>0, issue needs count<16
      if (do_commit) begin
        entry_q         <= {1'b0, head_q};
        des_q           <= rd_q[head_q];
        res_q           <= result_q[head_q];
        valid_q[head_q] <= FALSE;
        head_q          <= head_q + 4'd1;
        if (mispredict) begin
          state_q    <= ST_FLUSH;
          flush_pc_q <= redirect_pc(taken_q[head_q], target_q[head_q], pc_q[head_q]);
        end
      end
      if (do_issue) begin
        valid_q[tail_q] <= TRUE;
        ready_q[tail_q] <= FALSE;
        rd_q[tail_q]    <= rob.issue_rd;
        br_q[tail_q]    <= rob.issue_is_br;
        pred_q[tail_q]  <= rob.issue_pred;
        pc_q[tail_q]    <= rob.issue_pc;
        tail_q          <= tail_q + 4'd1;
      end
      count_q <= count_d;
    end
  end

endmodule
